// File: rtl/scene_packet_decoder_pkg.sv
// Shared types and constants for the scene packet decoder.
package scene_packet_decoder_pkg;

   localparam int unsigned WORD_W     = 64;
   localparam int unsigned HDR_RSVD_W = 40;

   localparam logic [7:0] MAGIC   = 8'hA5;
   localparam logic [7:0] OP_LOAD = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PAYLOAD   = 2'd1,
      ST_TRAILER   = 2'd2,
      ST_WAIT_SWAP = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_HEADER   = 2'd1,
      ERR_CHECKSUM = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_e;

   typedef struct packed {
      logic [7:0]            magic;
      logic [7:0]            opcode;
      logic [7:0]            count;
      logic [HDR_RSVD_W-1:0] rsvd;
   } hdr_t;

   // A header is usable only if the object count fits the scene RAM.
   function automatic logic hdr_valid(input logic [7:0] magic,
                                      input logic [7:0] opcode,
                                      input logic [7:0] count,
                                      input logic [7:0] max_obj);
      return (magic == MAGIC) && (opcode == OP_LOAD) &&
             (count != 8'd0) && (count <= max_obj);
   endfunction

endpackage

// File: rtl/scene_packet_decoder_timer.sv
// Loadable down-counter that pulses once, registered, when it runs down to zero.
module scene_packet_decoder_timer
   import scene_packet_decoder_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Load wins over clear so a restart in the same cycle as a clear is kept.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d     = cnt_q - CNT_W'(1);
         expired_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/scene_packet_decoder.sv
// Parses framed scene packets into the back bank of a double-buffered scene RAM
// and swaps banks on the frame boundary following a checksum-clean packet.
module scene_packet_decoder
   import scene_packet_decoder_pkg::*;
#(
   parameter int unsigned MAX_OBJ        = 16,
   parameter int unsigned WORDS_PER_OBJ  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1250000,
   parameter int unsigned ADDR_W         = $clog2(MAX_OBJ * WORDS_PER_OBJ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_word_dv,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_frame_start,
   output logic              o_wr_en,
   output logic              o_wr_bank,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [WORD_W-1:0] o_wr_data,
   output logic              o_active_bank,
   output logic [7:0]        o_obj_count,
   output logic              o_commit,
   output logic              o_recv_interrupt,
   output logic [7:0]        o_err_count,
   output logic [1:0]        o_last_err
);

   localparam int unsigned       TMR_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        MAX_OBJ_B = 8'(MAX_OBJ);

   state_e            state_q, state_d;

   logic [7:0]        count_q, count_d;
   logic [7:0]        pend_q, pend_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] last_idx_q, last_idx_d;
   logic [WORD_W-1:0] csum_q, csum_d;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic              active_bank_q, active_bank_d;
   logic              wr_bank_q, wr_bank_d;
   logic [7:0]        obj_count_q, obj_count_d;
   logic              commit_q, commit_d;
   logic              irq_q, irq_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   err_code_e         last_err_q, last_err_d;

   hdr_t              hdr_c;
   logic              hdr_ok_c;
   logic              last_word_c;
   logic              csum_ok_c;
   logic              err_c;
   err_code_e         err_code_c;
   logic              tmr_load_c;
   logic              tmr_clear_c;
   logic              tmr_en_c;
   logic              tmr_expired;
   logic              unused_rsvd_c;

   assign hdr_c         = hdr_t'(i_word);
   assign hdr_ok_c      = hdr_valid(hdr_c.magic, hdr_c.opcode, hdr_c.count, MAX_OBJ_B);
   assign last_word_c   = (idx_q == last_idx_q);
   assign csum_ok_c     = (i_word == csum_q);
   assign unused_rsvd_c = ^hdr_c.rsvd;

   // The inter-word timer only runs while a packet is in flight.
   assign tmr_clear_c = (state_q == ST_IDLE) || (state_q == ST_WAIT_SWAP);
   assign tmr_en_c    = ~tmr_clear_c;

   scene_packet_decoder_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_c),
      .load_val_i (TMR_LOAD),
      .clear_i    (tmr_clear_c),
      .en_i       (tmr_en_c),
      .expired_o  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An arriving word always takes priority over a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_word_dv && hdr_ok_c) begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (i_word_dv) begin
               if (last_word_c) begin
                  state_d = ST_TRAILER;
               end
            end else if (tmr_expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_TRAILER: begin
            if (i_word_dv) begin
               state_d = csum_ok_c ? ST_WAIT_SWAP : ST_IDLE;
            end else if (tmr_expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_SWAP: begin
            if (i_frame_start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d       = count_q;
      pend_d        = pend_q;
      idx_d         = idx_q;
      last_idx_d    = last_idx_q;
      csum_d        = csum_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      active_bank_d = active_bank_q;
      wr_bank_d     = wr_bank_q;
      obj_count_d   = obj_count_q;
      commit_d      = 1'b0;
      err_cnt_d     = err_cnt_q;
      last_err_d    = last_err_q;
      err_c         = 1'b0;
      err_code_c    = ERR_NONE;
      tmr_load_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_word_dv) begin
               if (hdr_ok_c) begin
                  count_d    = hdr_c.count;
                  last_idx_d = ADDR_W'(16'(hdr_c.count) * 16'(WORDS_PER_OBJ) - 16'd1);
                  idx_d      = '0;
                  csum_d     = '0;
                  tmr_load_c = 1'b1;
               end else begin
                  err_c      = 1'b1;
                  err_code_c = ERR_HEADER;
               end
            end
         end
         ST_PAYLOAD: begin
            if (i_word_dv) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = idx_q;
               wr_data_d  = i_word;
               csum_d     = csum_q ^ i_word;
               tmr_load_c = 1'b1;
               if (!last_word_c) begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end else if (tmr_expired) begin
               err_c      = 1'b1;
               err_code_c = ERR_TIMEOUT;
            end
         end
         ST_TRAILER: begin
            if (i_word_dv) begin
               if (csum_ok_c) begin
                  pend_d = count_q;
               end else begin
                  err_c      = 1'b1;
                  err_code_c = ERR_CHECKSUM;
               end
            end else if (tmr_expired) begin
               err_c      = 1'b1;
               err_code_c = ERR_TIMEOUT;
            end
         end
         ST_WAIT_SWAP: begin
            if (i_frame_start) begin
               active_bank_d = ~active_bank_q;
               wr_bank_d     = active_bank_q;
               obj_count_d   = pend_q;
               commit_d      = 1'b1;
            end
            // No buffer space until the swap: the word is dropped.
            if (i_word_dv) begin
               err_c      = 1'b1;
               err_code_c = ERR_TIMEOUT;
            end
         end
         default: ;
      endcase

      irq_d = (state_d != ST_WAIT_SWAP);

      if (err_c) begin
         last_err_d = err_code_c;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= '0;
         pend_q        <= '0;
         idx_q         <= '0;
         last_idx_q    <= '0;
         csum_q        <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         active_bank_q <= 1'b0;
         wr_bank_q     <= 1'b1;
         obj_count_q   <= '0;
         commit_q      <= 1'b0;
         irq_q         <= 1'b1;
         err_cnt_q     <= '0;
         last_err_q    <= ERR_NONE;
      end else begin
         count_q       <= count_d;
         pend_q        <= pend_d;
         idx_q         <= idx_d;
         last_idx_q    <= last_idx_d;
         csum_q        <= csum_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         active_bank_q <= active_bank_d;
         wr_bank_q     <= wr_bank_d;
         obj_count_q   <= obj_count_d;
         commit_q      <= commit_d;
         irq_q         <= irq_d;
         err_cnt_q     <= err_cnt_d;
         last_err_q    <= last_err_d;
      end
   end

   assign o_wr_en          = wr_en_q;
   assign o_wr_bank        = wr_bank_q;
   assign o_wr_addr        = wr_addr_q;
   assign o_wr_data        = wr_data_q;
   assign o_active_bank    = active_bank_q;
   assign o_obj_count      = obj_count_q;
   assign o_commit         = commit_q;
   assign o_recv_interrupt = irq_q;
   assign o_err_count      = err_cnt_q;
   assign o_last_err       = last_err_q;

endmodule

// File: tb/tb_scene_packet_decoder.sv
// Directed-sequence bench with randomized packet contents, checked against a
// packet-level model of bank ownership, object counts and error bookkeeping.
module tb_scene_packet_decoder;

   localparam int unsigned MAX_OBJ = 16;
   localparam int unsigned WPO     = 2;
   localparam int unsigned TMO     = 100;
   localparam int unsigned AW      = $clog2(MAX_OBJ * WPO);

   logic          clk = 1'b0;
   logic          rst;
   logic          i_word_dv;
   logic [63:0]   i_word;
   logic          i_frame_start;
   logic          o_wr_en;
   logic          o_wr_bank;
   logic [AW-1:0] o_wr_addr;
   logic [63:0]   o_wr_data;
   logic          o_active_bank;
   logic [7:0]    o_obj_count;
   logic          o_commit;
   logic          o_recv_interrupt;
   logic [7:0]    o_err_count;
   logic [1:0]    o_last_err;

   scene_packet_decoder #(
      .MAX_OBJ        (MAX_OBJ),
      .WORDS_PER_OBJ  (WPO),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_word_dv        (i_word_dv),
      .i_word           (i_word),
      .i_frame_start    (i_frame_start),
      .o_wr_en          (o_wr_en),
      .o_wr_bank        (o_wr_bank),
      .o_wr_addr        (o_wr_addr),
      .o_wr_data        (o_wr_data),
      .o_active_bank    (o_active_bank),
      .o_obj_count      (o_obj_count),
      .o_commit         (o_commit),
      .o_recv_interrupt (o_recv_interrupt),
      .o_err_count      (o_err_count),
      .o_last_err       (o_last_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          bank;
      logic [AW-1:0] addr;
      logic [63:0]   data;
   } wr_t;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit          m_bank;
   int          m_count;
   int          m_errs;
   int          m_last;
   bit          m_wait;
   int          m_pending;
   int          m_commits    = 0;
   int          seen_commits = 0;
   logic [63:0] exp_pl[$];
   wr_t         wr_log[$];
   int          mark;

   always @(negedge clk) begin
      if (o_wr_en) wr_log.push_back('{o_wr_bank, o_wr_addr, o_wr_data});
      if (o_commit) seen_commits++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":active_bank"}, 64'(o_active_bank), 64'(m_bank));
      chk({tag, ":wr_bank"}, 64'(o_wr_bank), 64'(!m_bank));
      chk({tag, ":obj_count"}, 64'(o_obj_count), 64'(m_count));
      chk({tag, ":err_count"}, 64'(o_err_count), 64'(m_errs));
      chk({tag, ":last_err"}, 64'(o_last_err), 64'(m_last));
      chk({tag, ":recv_irq"}, 64'(o_recv_interrupt), 64'(!m_wait));
   endtask

   task automatic model_err(input int code);
      if (m_errs < 255) m_errs++;
      m_last = code;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [63:0] w, input bit fs);
      i_word        = w;
      i_word_dv     = 1'b1;
      i_frame_start = fs;
      @(posedge clk);
      #1;
      i_word_dv     = 1'b0;
      i_frame_start = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      i_word_dv     = 1'b0;
      i_frame_start = 1'b0;
      idle(3);
      rst       = 1'b0;
      m_bank    = 1'b0;
      m_count   = 0;
      m_errs    = 0;
      m_last    = 0;
      m_wait    = 1'b0;
      m_pending = 0;
   endtask

   task automatic fill_random(input int n);
      exp_pl.delete();
      for (int i = 0; i < n * int'(WPO); i++) exp_pl.push_back({$urandom, $urandom});
   endtask

   function automatic logic [63:0] hdr_word(input int n);
      return {8'hA5, 8'h01, 8'(n), 8'($urandom), $urandom};
   endfunction

   // Sends header, exp_pl as payload and the XOR trailer (optionally corrupted).
   task automatic send_packet(input int n, input logic [63:0] csum_mask,
                              input int gap_lo, input int gap_hi, input bit fs_with_trailer);
      logic [63:0] cs;
      cs = '0;
      foreach (exp_pl[i]) cs ^= exp_pl[i];
      send_word(hdr_word(n), 1'b0);
      foreach (exp_pl[i]) begin
         idle(int'($urandom_range(gap_hi, gap_lo)));
         send_word(exp_pl[i], 1'b0);
      end
      idle(int'($urandom_range(gap_hi, gap_lo)));
      send_word(cs ^ csum_mask, fs_with_trailer);
      if (csum_mask != '0) begin
         model_err(2);
      end else begin
         m_wait    = 1'b1;
         m_pending = n;
      end
   endtask

   task automatic check_writes(input string tag, input int from, input bit bank);
      chk({tag, ":nwrites"}, 64'(wr_log.size() - from), 64'(exp_pl.size()));
      for (int i = 0; i < exp_pl.size() && (from + i) < wr_log.size(); i++) begin
         chk({tag, ":wr_bank"}, 64'(wr_log[from + i].bank), 64'(bank));
         chk({tag, ":wr_addr"}, 64'(wr_log[from + i].addr), 64'(i));
         chk({tag, ":wr_data"}, wr_log[from + i].data, exp_pl[i]);
      end
   endtask

   task automatic frame_pulse(input string tag);
      bit expect_commit;
      expect_commit = m_wait;
      i_frame_start = 1'b1;
      @(posedge clk);
      #1;
      i_frame_start = 1'b0;
      if (m_wait) begin
         m_bank  = ~m_bank;
         m_count = m_pending;
         m_wait  = 1'b0;
         m_commits++;
      end
      chk({tag, ":commit"}, 64'(o_commit), 64'(expect_commit));
      check_state(tag);
      idle(1);
      chk({tag, ":commit_drop"}, 64'(o_commit), 64'd0);
      chk({tag, ":commit_total"}, 64'(seen_commits), 64'(m_commits));
   endtask

   initial begin
      logic [63:0] bad_hdr[4];
      int          n;
      logic [7:0]  mg;

      i_word = '0;
      do_reset();
      check_state("reset");
      chk("reset:wr_en", 64'(o_wr_en), 64'd0);
      chk("reset:commit", 64'(o_commit), 64'd0);

      // Directed good packet: payload 1,2,4,8 and trailer 0xF
      exp_pl = '{64'h1, 64'h2, 64'h4, 64'h8};
      mark   = wr_log.size();
      send_packet(2, 64'h0, 0, 0, 1'b0);
      check_state("good_wait");
      check_writes("good", mark, 1'b1);
      frame_pulse("good_swap");

      // Same payload, trailer 0xE
      mark = wr_log.size();
      send_packet(2, 64'h1, 0, 0, 1'b0);
      check_state("badcs");
      check_writes("badcs", mark, !m_bank);
      frame_pulse("badcs_frame");

      // Bad headers: wrong magic, N=0, N=17, wrong opcode
      bad_hdr[0] = 64'h5A01_0200_0000_0000;
      bad_hdr[1] = 64'hA501_0000_0000_0000;
      bad_hdr[2] = 64'hA501_1100_0000_0000;
      bad_hdr[3] = 64'hA502_0200_0000_0000;
      for (int i = 0; i < 4; i++) begin
         mark = wr_log.size();
         send_word(bad_hdr[i], 1'b0);
         idle(2);
         model_err(1);
         chk("badhdr:nwrites", 64'(wr_log.size() - mark), 64'd0);
         check_state("badhdr");
      end

      // Random good packets with gaps; stray frame pulses while idle are ignored
      for (int k = 0; k < 5; k++) begin
         frame_pulse("idle_frame");
         n = (k == 0) ? int'(MAX_OBJ) : int'($urandom_range(MAX_OBJ, 1));
         fill_random(n);
         mark = wr_log.size();
         send_packet(n, 64'h0, 0, 20, 1'b0);
         check_state("rnd_wait");
         check_writes("rnd", mark, !m_bank);
         frame_pulse("rnd_swap");
      end

      // Gaps of exactly TMO-1 idle cycles must not time out
      fill_random(1);
      mark = wr_log.size();
      send_packet(1, 64'h0, int'(TMO) - 1, int'(TMO) - 1, 1'b0);
      check_state("gap_edge");
      check_writes("gap_edge", mark, !m_bank);
      frame_pulse("gap_edge_swap");

      // Timeout after one payload word
      fill_random(1);
      mark = wr_log.size();
      send_word(hdr_word(1), 1'b0);
      send_word(exp_pl[0], 1'b0);
      idle(int'(TMO) - 1);
      check_state("tmo_before");
      idle(1);
      model_err(3);
      check_state("tmo_after");
      chk("tmo:nwrites", 64'(wr_log.size() - mark), 64'd1);
      fill_random(3);
      mark = wr_log.size();
      send_packet(3, 64'h0, 0, 5, 1'b0);
      check_writes("after_tmo", mark, !m_bank);
      frame_pulse("after_tmo_swap");

      // Trailer coincident with frame start, then an overflow word while waiting
      n = int'($urandom_range(MAX_OBJ, 1));
      fill_random(n);
      mark = wr_log.size();
      send_packet(n, 64'h0, 0, 3, 1'b1);
      idle(1);
      check_state("coinc");
      chk("coinc:commit_total", 64'(seen_commits), 64'(m_commits));
      check_writes("coinc", mark, !m_bank);
      mark = wr_log.size();
      send_word({$urandom, $urandom}, 1'b0);
      idle(2);
      model_err(3);
      chk("ovf:nwrites", 64'(wr_log.size() - mark), 64'd0);
      check_state("ovf");
      frame_pulse("coinc_swap");

      // Reset in the middle of a payload
      fill_random(4);
      send_word(hdr_word(4), 1'b0);
      for (int i = 0; i < 3; i++) send_word(exp_pl[i], 1'b0);
      do_reset();
      check_state("rst_mid");
      chk("rst_mid:wr_en", 64'(o_wr_en), 64'd0);
      fill_random(2);
      mark = wr_log.size();
      send_packet(2, 64'h0, 0, 2, 1'b0);
      check_writes("post_rst", mark, 1'b1);
      frame_pulse("post_rst_swap");

      // 300 bad headers saturate the error counter
      mark = wr_log.size();
      for (int i = 0; i < 300; i++) begin
         mg = 8'($urandom_range(255, 0));
         if (mg == 8'hA5) mg = 8'h5A;
         send_word({mg, 8'h01, 8'h02, 40'($urandom)}, 1'b0);
         model_err(1);
      end
      idle(2);
      chk("sat:nwrites", 64'(wr_log.size() - mark), 64'd0);
      check_state("sat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
